// File: rtl/rs232_packet_rx.sv
// Serial 8N1 receiver that gathers N frames into one N*n-bit packet word.
// Optional even-parity checking is compiled in with `define RS232_RX_PARITY_EN.
module rs232_packet_rx #(
  parameter int N            = 8,
  parameter int n            = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic                 start_flag,
  output logic [N*n-1:0]       data_out,
  output logic                 done_flag,
  output logic                 frame_err,
  output logic                 busy,
  output logic [$clog2(N):0]   byte_idx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(n + 1);
  localparam int IW = $clog2(N) + 1;

  localparam logic [BW-1:0] HALF_M1  = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_M1  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(n - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

`ifdef RS232_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;
`endif

  state_t           state_reg, state_next;
  logic [1:0]       sync_reg;
  logic             rxs;
  logic [BW-1:0]    baud_reg, baud_next;
  logic [CW-1:0]    bit_reg, bit_next;
  logic [n-1:0]     shift_reg, shift_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [N*n-1:0]   slot_reg, slot_next, slot_merged;
  logic [N*n-1:0]   data_reg, data_next;
  logic             start_reg, start_next;
  logic             done_reg, done_next;
  logic             ferr_reg, ferr_next;
  logic             tick_half, tick_full;
`ifdef RS232_RX_PARITY_EN
  logic             par_err_reg, par_err_next;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_reg <= 2'b11;
    else        sync_reg <= {sync_reg[0], rx_in};
  end
  assign rxs = sync_reg[1];

  assign tick_half = (baud_reg == HALF_M1);
  assign tick_full = (baud_reg == FULL_M1);

  // Slot buffer with the freshly received byte dropped into position idx_reg.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    assign slot_merged[gi*n +: n] = (idx_reg == IW'(gi)) ? shift_reg : slot_reg[gi*n +: n];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      idx_reg     <= '0;
      slot_reg    <= '0;
      data_reg    <= '0;
      start_reg   <= 1'b0;
      done_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
`ifdef RS232_RX_PARITY_EN
      par_err_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      idx_reg     <= idx_next;
      slot_reg    <= slot_next;
      data_reg    <= data_next;
      start_reg   <= start_next;
      done_reg    <= done_next;
      ferr_reg    <= ferr_next;
`ifdef RS232_RX_PARITY_EN
      par_err_reg <= par_err_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_next     = bit_reg;
    shift_next   = shift_reg;
    idx_next     = idx_reg;
    slot_next    = slot_reg;
    data_next    = data_reg;
    start_next   = 1'b0;
    done_next    = 1'b0;
    ferr_next    = 1'b0;
`ifdef RS232_RX_PARITY_EN
    par_err_next = par_err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!rxs) begin
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (tick_half) begin
          baud_next = '0;
          if (rxs) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            bit_next   = '0;
            start_next = (idx_reg == '0);
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      DATA: begin
        if (tick_full) begin
          baud_next  = '0;
          shift_next = {rxs, shift_reg[n-1:1]};
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == LAST_BIT) begin
`ifdef RS232_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
`ifdef RS232_RX_PARITY_EN
      PARITY: begin
        if (tick_full) begin
          baud_next    = '0;
          par_err_next = ^{shift_reg, rxs};
          state_next   = STOP;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick_full) begin
          baud_next = '0;
          if (!rxs) begin
            ferr_next  = 1'b1;
            idx_next   = '0;
            state_next = RECOVER;
`ifdef RS232_RX_PARITY_EN
          end else if (par_err_reg) begin
            ferr_next  = 1'b1;
            idx_next   = '0;
            state_next = IDLE;
`endif
          end else begin
            slot_next  = slot_merged;
            state_next = IDLE;
            if (idx_reg == LAST_IDX) begin
              data_next = slot_merged;
              done_next = 1'b1;
              idx_next  = '0;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      RECOVER: begin
        // Line held low after a bad stop bit: wait for idle before hunting again.
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign start_flag = start_reg;
  assign done_flag  = done_reg;
  assign frame_err  = ferr_reg;
  assign data_out   = data_reg;
  assign byte_idx   = idx_reg;
  assign busy       = (state_reg != IDLE) || (idx_reg != '0);

endmodule
